// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared types and fixed-point helpers for the boid frame engine
package boid_pkg;

    localparam int W    = 32;
    localparam int FRAC = 16;

    typedef logic signed [W-1:0] fix_t;

    typedef struct packed {
        fix_t x;
        fix_t y;
        fix_t vx;
        fix_t vy;
    } boid_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEER,
        CLAMP,
        EMIT,
        FIN
    } state_t;

    // Integer pixels to Q(W-FRAC).FRAC
    function automatic fix_t to_fix(input int v);
        return fix_t'(v) <<< FRAC;
    endfunction

endpackage

// File: rtl/boid_kinematics.sv
// rtl/boid_kinematics.sv - combinational steer, speed clamp and integrate for one boid
//
// Ports:
//   cur  in   boid_t  boid state before this frame
//   nxt  out  boid_t  steered and clamped velocity, position advanced by that velocity
module boid_kinematics import boid_pkg::*; #(
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int MARGIN = 100,
    parameter int TURN   = 'h1999,
    parameter int VMIN   = 4,
    parameter int VMAX   = 8
) (
    input  boid_t cur,
    output boid_t nxt
);

    localparam fix_t LO     = to_fix(MARGIN);
    localparam fix_t HI_X   = to_fix(SCR_W - MARGIN);
    localparam fix_t HI_Y   = to_fix(SCR_H - MARGIN);
    localparam fix_t TURN_F = fix_t'(TURN);
    localparam fix_t VMIN_F = to_fix(VMIN);
    localparam fix_t VMAX_F = to_fix(VMAX);

    function automatic fix_t steer(input fix_t p, input fix_t v, input fix_t hi);
        fix_t r;
        r = v;
        if (p < LO)
            r = v + TURN_F;
        else if (p > hi)
            r = v - TURN_F;
        return r;
    endfunction

    function automatic fix_t mag(input fix_t v);
        return v[W-1] ? -v : v;
    endfunction

    fix_t sx, sy, ax, ay, mag_hi, mag_lo, spd, cx, cy;

    always_comb begin
        sx = steer(cur.x, cur.vx, HI_X);
        sy = steer(cur.y, cur.vy, HI_Y);
        ax = mag(sx);
        ay = mag(sy);
        mag_hi = (ax > ay) ? ax : ay;
        mag_lo = (ax > ay) ? ay : ax;
        // alpha-max-plus-beta-min speed estimate, avoids a square root
        spd = mag_hi + (mag_lo >>> 1);
        cx = sx;
        cy = sy;
        if (spd < VMIN_F) begin
            cx = sx + (sx >>> 2);
            cy = sy + (sy >>> 2);
        end else if (spd > VMAX_F) begin
            cx = sx - (sx >>> 2);
            cy = sy - (sy >>> 2);
        end
        nxt.x  = cur.x + cx;
        nxt.y  = cur.y + cy;
        nxt.vx = cx;
        nxt.vy = cy;
    end

endmodule

// File: rtl/boid_frame_engine.sv
// rtl/boid_frame_engine.sv - sequential per-frame update of NUM_BOIDS boids streamed to the drawer
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start / busy / done     frame request, in-progress flag, end-of-frame pulse
//   ld_en, ld_idx, ld_*     write one boid's state while idle
//   out_valid / out_ready   handshake for each updated boid
//   out_idx, x, y, vx, vy   updated boid
//   px, py                  position before the update, for erase
module boid_frame_engine import boid_pkg::*; #(
    parameter int NUM_BOIDS = 8,
    parameter int SCR_W     = 640,
    parameter int SCR_H     = 480,
    parameter int MARGIN    = 100,
    parameter int TURN      = 'h1999,
    parameter int VMIN      = 4,
    parameter int VMAX      = 8,
    localparam int IW       = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                ld_en,
    input  logic [IW-1:0]       ld_idx,
    input  logic signed [W-1:0] ld_x,
    input  logic signed [W-1:0] ld_y,
    input  logic signed [W-1:0] ld_vx,
    input  logic signed [W-1:0] ld_vy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW-1:0]       out_idx,
    output logic signed [W-1:0] x,
    output logic signed [W-1:0] y,
    output logic signed [W-1:0] px,
    output logic signed [W-1:0] py,
    output logic signed [W-1:0] vx,
    output logic signed [W-1:0] vy
);

    localparam logic [IW-1:0] LAST = IW'(NUM_BOIDS - 1);

    state_t        state;
    logic [IW-1:0] idx;
    boid_t         boids [NUM_BOIDS];
    boid_t         work;
    boid_t         res;
    boid_t         kin_nxt;

    boid_kinematics #(
        .SCR_W  (SCR_W),
        .SCR_H  (SCR_H),
        .MARGIN (MARGIN),
        .TURN   (TURN),
        .VMIN   (VMIN),
        .VMAX   (VMAX)
    ) u_kin (
        .cur (work),
        .nxt (kin_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            x         <= '0;
            y         <= '0;
            px        <= '0;
            py        <= '0;
            vx        <= '0;
            vy        <= '0;
            work      <= '0;
            res       <= '0;
            for (int i = 0; i < NUM_BOIDS; i++) begin
                boids[i] <= '{x: to_fix(120 + 40 * i), y: to_fix(120 + 40 * i),
                              vx: to_fix(5), vy: to_fix(4)};
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // a load in the same cycle as start lands before LOAD reads the array
                    if (ld_en && (int'(ld_idx) < NUM_BOIDS))
                        boids[ld_idx] <= '{x: ld_x, y: ld_y, vx: ld_vx, vy: ld_vy};
                    if (start) begin
                        state <= LOAD;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    work  <= boids[idx];
                    state <= STEER;
                end
                STEER: begin
                    // register the whole steer/clamp/integrate chain so it never
                    // feeds the output registers in the same cycle
                    res   <= kin_nxt;
                    state <= CLAMP;
                end
                CLAMP: begin
                    x         <= res.x;
                    y         <= res.y;
                    px        <= work.x;
                    py        <= work.y;
                    vx        <= res.vx;
                    vy        <= res.vy;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        boids[idx] <= '{x: x, y: y, vx: vx, vy: vy};
                        out_valid  <= 1'b0;
                        if (idx == LAST) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= LOAD;
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boid_frame_engine.sv
// tb/tb_boid_frame_engine.sv - self-checking bench for boid_frame_engine
module tb_boid_frame_engine;

    localparam int N      = 8;
    localparam int FR     = 65536;
    localparam int TURN_I = 'h1999;

    logic clk = 1'b0;
    logic reset, start, busy, done, ld_en, out_valid, out_ready;
    logic [2:0] ld_idx, out_idx;
    logic signed [31:0] ld_x, ld_y, ld_vx, ld_vy, x, y, px, py, vx, vy;

    always #5 clk = ~clk;

    boid_frame_engine #(.NUM_BOIDS(N)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y), .ld_vx(ld_vx), .ld_vy(ld_vy),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .x(x), .y(y), .px(px), .py(py), .vx(vx), .vy(vy)
    );

    typedef struct packed {
        logic        b;
        logic        v;
        logic [31:0] idx;
        logic [31:0] x, y, px, py, vx, vy;
    } rec_t;

    rec_t emits[$];
    rec_t stalls[$];
    int mx[N], my[N], mvx[N], mvy[N];
    int n_tests = 0;
    int n_fail = 0;

    function automatic rec_t snap();
        rec_t r;
        r.b = busy; r.v = out_valid; r.idx = 32'(out_idx);
        r.x = x; r.y = y; r.px = px; r.py = py; r.vx = vx; r.vy = vy;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = (120 + 40 * i) * FR; my[i] = mx[i];
            mvx[i] = 5 * FR; mvy[i] = 4 * FR;
        end
    endfunction

    // Expected emission for boid i; also commits it into the model
    function automatic rec_t model_boid(input int i);
        rec_t r;
        int nvx, nvy, ax, ay, s;
        nvx = mvx[i]; nvy = mvy[i];
        if (mx[i] < 100 * FR) nvx = nvx + TURN_I;
        else if (mx[i] > 540 * FR) nvx = nvx - TURN_I;
        if (my[i] < 100 * FR) nvy = nvy + TURN_I;
        else if (my[i] > 380 * FR) nvy = nvy - TURN_I;
        ax = (nvx < 0) ? -nvx : nvx;
        ay = (nvy < 0) ? -nvy : nvy;
        s = (ax > ay) ? ax + ay / 2 : ay + ax / 2;
        if (s < 4 * FR) begin
            nvx = nvx + (nvx >>> 2); nvy = nvy + (nvy >>> 2);
        end else if (s > 8 * FR) begin
            nvx = nvx - (nvx >>> 2); nvy = nvy - (nvy >>> 2);
        end
        r.b = 1'b1; r.v = 1'b1; r.idx = i;
        r.px = mx[i]; r.py = my[i];
        r.x = mx[i] + nvx; r.y = my[i] + nvy; r.vx = nvx; r.vy = nvy;
        mx[i] = r.x; my[i] = r.y; mvx[i] = nvx; mvy[i] = nvy;
        return r;
    endfunction

    task automatic load(input int i, input int lx, input int ly, input int lvx, input int lvy);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = 3'(i); ld_x = lx; ld_y = ly; ld_vx = lvx; ld_vy = lvy;
        @(negedge clk);
        ld_en = 1'b0;
        mx[i] = lx; my[i] = ly; mvx[i] = lvx; mvy[i] = lvy;
    endtask

    // mode 0: always ready, 1: random ready, 2: first 10 valid cycles stalled
    task automatic run_frame(input int mode, input bit with_ld, input bit intrude, output int done_cyc);
        int cnt, stall_left;
        emits.delete();
        stalls.delete();
        @(negedge clk);
        start = 1'b1; ld_en = with_ld;
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        cnt = 1; done_cyc = -1; stall_left = (mode == 2) ? 10 : 0;
        while (cnt < 2000) begin
            if (done) begin
                done_cyc = cnt;
                break;
            end
            start = 1'b0; ld_en = 1'b0;
            if (intrude && cnt == 10) begin
                start = 1'b1; ld_en = 1'b1; ld_idx = 3'd0;
                ld_x = 32'h0777_0000; ld_y = 32'h0777_0000; ld_vx = 32'h0001_0000; ld_vy = 32'h0;
            end
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                stalls.push_back(snap());
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid && out_ready) emits.push_back(snap());
            @(negedge clk);
            cnt++;
        end
        out_ready = 1'b1; start = 1'b0; ld_en = 1'b0;
    endtask

    task automatic test_reset();
        int dc;
        rec_t e;
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_idx = '0; out_ready = 1'b1;
        ld_x = '0; ld_y = '0; ld_vx = '0; ld_vy = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, out_valid});
        end
        n_tests++;
        if ({out_idx, x, y, px, py, vx, vy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got %h want 0", {out_idx, x, y, px, py, vx, vy});
        end
        model_reset();
        run_frame(0, 1'b0, 1'b0, dc);
        n_tests++;
        if (dc != 33) begin n_fail++; $display("FAIL t1_done_cycle got %0d want 33", dc); end
        n_tests++;
        if (emits.size() > 0 && {emits[0].x, emits[0].y, emits[0].px} !== {32'(125 * FR), 32'(124 * FR), 32'(120 * FR)}) begin
            n_fail++; $display("FAIL t1_boid0_pos got %h want 007d0000007c000000780000", {emits[0].x, emits[0].y, emits[0].px});
        end
        n_tests++;
        if (emits.size() != N) begin n_fail++; $display("FAIL t1_count got %0d want %0d", emits.size(), N); end
        for (int k = 0; k < N; k++) begin
            e = model_boid(k);
            if (k < emits.size()) begin
                n_tests++;
                if (emits[k] !== e) begin n_fail++; $display("FAIL t1_boid%0d got %h want %h", k, emits[k], e); end
            end
        end
    endtask

    task automatic test_steer();
        int dc;
        rec_t e;
        ld_idx = 3'd0; ld_x = 50 * FR; ld_y = 240 * FR; ld_vx = 4 * FR; ld_vy = 0;
        mx[0] = 50 * FR; my[0] = 240 * FR; mvx[0] = 4 * FR; mvy[0] = 0;
        run_frame(0, 1'b1, 1'b0, dc);
        n_tests++;
        if (emits.size() == 0 || {emits[0].vx, emits[0].x} !== {32'h0004_1999, 32'h0036_1999}) begin
            n_fail++; $display("FAIL t2_steer got %0d recs want vx=00041999 x=00361999", emits.size());
        end
        n_tests++;
        if (dc != 33) begin n_fail++; $display("FAIL t2_done_cycle got %0d want 33", dc); end
        for (int k = 0; k < N; k++) begin
            e = model_boid(k);
            if (k < emits.size()) begin
                n_tests++;
                if (emits[k] !== e) begin n_fail++; $display("FAIL t2_boid%0d got %h want %h", k, emits[k], e); end
            end
        end
    endtask

    task automatic test_clamp();
        int dc;
        rec_t e;
        // too fast: s=12 -> shrink by a quarter
        load(0, 320 * FR, 240 * FR, 8 * FR, 8 * FR);
        // too slow: s=1 -> grow by a quarter
        load(1, 320 * FR, 240 * FR, 1 * FR, 0);
        run_frame(0, 1'b0, 1'b0, dc);
        n_tests++;
        if (emits.size() < 2 || {emits[0].vx, emits[0].vy, emits[0].x, emits[0].y} !==
                {32'(6 * FR), 32'(6 * FR), 32'(326 * FR), 32'(246 * FR)}) begin
            n_fail++; $display("FAIL t3_clamp_high got %0d recs want vx=vy=6.0 x=326.0 y=246.0", emits.size());
        end
        n_tests++;
        if (emits.size() < 2 || {emits[1].vx, emits[1].x} !== {32'h0001_4000, 32'h0141_4000}) begin
            n_fail++; $display("FAIL t4_clamp_low got %0d recs want vx=00014000 x=01414000", emits.size());
        end
        for (int k = 0; k < N; k++) begin
            e = model_boid(k);
            if (k < emits.size()) begin
                n_tests++;
                if (emits[k] !== e) begin n_fail++; $display("FAIL t34_boid%0d got %h want %h", k, emits[k], e); end
            end
        end
    endtask

    task automatic test_stall();
        int dc;
        rec_t e;
        run_frame(2, 1'b0, 1'b0, dc);
        n_tests++;
        if (stalls.size() != 10) begin n_fail++; $display("FAIL t5_stall_count got %0d want 10", stalls.size()); end
        n_tests++;
        if (dc != 43) begin n_fail++; $display("FAIL t5_done_cycle got %0d want 43", dc); end
        for (int k = 0; k < N; k++) begin
            e = model_boid(k);
            if (k == 0) begin
                for (int j = 0; j < stalls.size(); j++) begin
                    n_tests++;
                    if (stalls[j] !== e) begin n_fail++; $display("FAIL t5_stall%0d got %h want %h", j, stalls[j], e); end
                end
            end
            if (k < emits.size()) begin
                n_tests++;
                if (emits[k] !== e) begin n_fail++; $display("FAIL t5_boid%0d got %h want %h", k, emits[k], e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        rec_t e;
        for (int f = 0; f < 2; f++) begin
            // second frame pokes start and ld_en mid-frame; both must be ignored
            run_frame(0, 1'b0, f == 1, dc);
            n_tests++;
            if (dc != 33) begin n_fail++; $display("FAIL b2b_done_cycle f%0d got %0d want 33", f, dc); end
            for (int k = 0; k < N; k++) begin
                e = model_boid(k);
                if (k < emits.size()) begin
                    n_tests++;
                    if (emits[k] !== e) begin n_fail++; $display("FAIL b2b_f%0d_boid%0d got %h want %h", f, k, emits[k], e); end
                end
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_random();
        int dc;
        rec_t e;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    load(i, int'($urandom_range(0, 640 * FR)), int'($urandom_range(0, 480 * FR)),
                         int'($urandom_range(0, 20 * FR)) - 10 * FR, int'($urandom_range(0, 20 * FR)) - 10 * FR);
            end
            run_frame(1, 1'b0, 1'b0, dc);
            n_tests++;
            if (dc < 33) begin n_fail++; $display("FAIL rnd_done f%0d got %0d want >=33", f, dc); end
            n_tests++;
            if (emits.size() != N) begin n_fail++; $display("FAIL rnd_count f%0d got %0d want %0d", f, emits.size(), N); end
            for (int k = 0; k < N; k++) begin
                e = model_boid(k);
                if (k < emits.size()) begin
                    n_tests++;
                    if (emits[k] !== e) begin n_fail++; $display("FAIL rnd_f%0d_boid%0d got %h want %h", f, k, emits[k], e); end
                end
            end
        end
    endtask

    task automatic test_midreset();
        int dc, cnt;
        bit seen;
        rec_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(out_valid && out_idx == 3'd3) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (!(out_valid && out_idx == 3'd3)) begin n_fail++; $display("FAIL t6_reach_boid3 got idx %0d want 3", out_idx); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_fail++; $display("FAIL t6_flags got %b want 000", {busy, done, out_valid});
        end
        n_tests++;
        if ({out_idx, x, y, px, py, vx, vy} !== '0) begin
            n_fail++; $display("FAIL t6_outputs got %h want 0", {out_idx, x, y, px, py, vx, vy});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL t6_done_after_reset got 1 want 0"); end
        model_reset();
        run_frame(0, 1'b0, 1'b1, dc);
        n_tests++;
        if (dc != 33) begin n_fail++; $display("FAIL t6_done_cycle got %0d want 33", dc); end
        for (int k = 0; k < N; k++) begin
            e = model_boid(k);
            if (k < emits.size()) begin
                n_tests++;
                if (emits[k] !== e) begin n_fail++; $display("FAIL t6_boid%0d got %h want %h", k, emits[k], e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steer();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
